// File: rtl/ibex_obi_arb_pkg.sv
// Shared types and constants for the two-port OBI to magic-memory arbiter.
package ibex_obi_arb_pkg;

  typedef logic [1:0] arb_state_e;
  localparam arb_state_e IDLE = 2'd0;
  localparam arb_state_e MEM  = 2'd1;
  localparam arb_state_e RESP = 2'd2;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  localparam int unsigned ARB_RR        = 0;
  localparam int unsigned ARB_DATA_PRIO = 1;

endpackage

// File: rtl/ibex_obi_mem_arbiter_rr_picker.sv
// Two-way winner select between fetch and LSU, with the round-robin history register.
module ibex_obi_rr_picker
  import ibex_obi_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  input  logic   instr_req_i,
  input  logic   data_req_i,
  output logic   valid_o,
  output owner_e winner_o
);

  owner_e last_q, last_d;

  // On a tie the port that was not granted last wins; data wins the first tie.
  always_comb begin
    winner_o = OWN_INSTR;
    if (ARB_MODE == ARB_DATA_PRIO) begin
      winner_o = data_req_i ? OWN_DATA : OWN_INSTR;
    end else if (instr_req_i && data_req_i) begin
      winner_o = (last_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    end else begin
      winner_o = data_req_i ? OWN_DATA : OWN_INSTR;
    end
  end

  assign valid_o = en_i & (instr_req_i | data_req_i);
  assign last_d  = valid_o ? winner_o : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWN_INSTR;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ibex_obi_mem_arbiter.sv
// Shares one single-outstanding magic-memory port between the ibex fetch and LSU OBI ports,
// with a watchdog that turns a hung memory into an OBI error response.
module ibex_obi_mem_arbiter
  import ibex_obi_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE       = ARB_RR,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TW             = 11
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_mbe_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_resp_i
);

  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  obi_req_t      req_q, req_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          pick_valid;
  owner_e        pick_owner;
  logic          timeout;

  // Grants are gated by reset so they drop asynchronously along with everything else.
  ibex_obi_rr_picker #(
    .ARB_MODE (ARB_MODE)
  ) u_picker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (rst_ni && (state_q == IDLE)),
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .valid_o     (pick_valid),
    .winner_o    (pick_owner)
  );

  assign instr_gnt_o = pick_valid & (pick_owner == OWN_INSTR);
  assign data_gnt_o  = pick_valid & (pick_owner == OWN_DATA);
  assign timeout     = (TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_owner;
          cnt_d   = '0;
          state_d = MEM;
          if (pick_owner == OWN_DATA) begin
            req_d = '{addr: data_addr_i, we: data_we_i, be: data_be_i, wdata: data_wdata_i};
          end else begin
            req_d = '{addr: instr_addr_i, we: 1'b0, be: 4'hF, wdata: 32'h0};
          end
        end
      end
      MEM: begin
        // A response landing on the timeout cycle still counts as a normal completion.
        if (mem_resp_i) begin
          rdata_d = req_q.we ? 32'h0 : mem_rdata_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= OWN_INSTR;
      req_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_read_o     = (state_q == MEM) & ~req_q.we;
  assign mem_write_o    = (state_q == MEM) & req_q.we;
  assign mem_mbe_o      = req_q.be;
  assign mem_addr_o     = {req_q.addr[31:2], 2'b00};
  assign mem_wdata_o    = req_q.wdata;

  assign instr_rvalid_o = (state_q == RESP) & (owner_q == OWN_INSTR);
  assign data_rvalid_o  = (state_q == RESP) & (owner_q == OWN_DATA);
  assign instr_rdata_o  = rdata_q;
  assign data_rdata_o   = rdata_q;
  assign instr_err_o    = instr_rvalid_o & err_q;
  assign data_err_o     = data_rvalid_o & err_q;

endmodule
